// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined signed adder tree: tree geometry and
// signed saturation on a 64-bit working width.
package adder_pkg;

  typedef logic signed [63:0] wide_t;

  typedef struct packed {
    wide_t value;
    logic  ovf;
  } sat_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

  function automatic wide_t max_of(input int width);
    return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t min_of(input int width);
    return -(wide_t'(1) <<< (width - 1));
  endfunction

  function automatic sat_t saturate(input wide_t s, input int width);
    sat_t r;
    r.ovf   = (s > max_of(width)) || (s < min_of(width));
    r.value = (s > max_of(width)) ? max_of(width) :
              (s < min_of(width)) ? min_of(width) : s;
    return r;
  endfunction

  // Bit offset of tree level lvl inside the flattened tree bus; level j holds
  // p>>j words of width+j bits.
  function automatic int level_offset(input int p, input int width, input int lvl);
    int off;
    off = 0;
    for (int j = 0; j < lvl; j++) off += (p >> j) * (width + j);
    return off;
  endfunction

endpackage

// File: rtl/pipelined_adder_tree_if.sv
// Sample/result bus of the pipelined adder tree; master drives samples,
// slave (the tree) returns results.
interface pipelined_adder_tree_if #(
  parameter int N_WORDS = 4,
  parameter int WIDTH   = 25
);
  localparam int OUT_WIDTH = WIDTH + adder_pkg::clog2(N_WORDS);

  logic                       IN_VALID;
  logic [N_WORDS*WIDTH-1:0]   WORDS;
  logic                       SAT_EN;
  logic                       OUT_VALID;
  logic [OUT_WIDTH-1:0]       RES;
  logic                       OVF;

  modport master (output IN_VALID, WORDS, SAT_EN, input OUT_VALID, RES, OVF);
  modport slave  (input IN_VALID, WORDS, SAT_EN, output OUT_VALID, RES, OVF);
endinterface

// File: rtl/adder_level.sv
// One registered level of the adder tree: IN_COUNT signed words of IN_WIDTH
// bits are summed pairwise into IN_COUNT/2 words of IN_WIDTH+1 bits.
module adder_level #(
  parameter int IN_COUNT = 4,
  parameter int IN_WIDTH = 25
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  valid_i,
  input  logic [IN_COUNT*IN_WIDTH-1:0]          data_i,
  output logic                                  valid_o,
  output logic [(IN_COUNT/2)*(IN_WIDTH+1)-1:0]  data_o
);
  localparam int OW = IN_WIDTH + 1;
  localparam int OC = IN_COUNT / 2;

  logic          valid_q;
  logic [OC*OW-1:0] sum_d;
  logic [OC*OW-1:0] sum_q;

  // NOTE: a default for every combinational output comes first so no path can infer a latch.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < OC; k++) begin
      sum_d[k*OW +: OW] = OW'($signed(data_i[(2*k)*IN_WIDTH +: IN_WIDTH]))
                        + OW'($signed(data_i[(2*k+1)*IN_WIDTH +: IN_WIDTH]));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) valid_q <= 1'b0;
    else     valid_q <= valid_i;
  end

  // NOTE: datapath registers are deliberately not reset; the valid bit alone qualifies them.
  always_ff @(posedge CLK) begin
    if (valid_i) sum_q <= sum_d;
  end

  assign valid_o = valid_q;
  assign data_o  = sum_q;
endmodule

// File: rtl/pipelined_adder_tree.sv
// Fully pipelined signed adder tree with per-sample saturation and an
// overflow flag; one sample per clock, latency STAGES+1.
module pipelined_adder_tree
  import adder_pkg::*;
#(
  parameter int N_WORDS = 4,
  parameter int WIDTH   = 25
) (
  input logic                   CLK,
  input logic                   RST,
  pipelined_adder_tree_if.slave bus
);
  localparam int STAGES    = clog2(N_WORDS);
  localparam int OUT_WIDTH = WIDTH + STAGES;
  localparam int P         = 1 << STAGES;
  localparam int TREE_BITS = level_offset(P, WIDTH, STAGES + 1);
  localparam int LAST_OFF  = level_offset(P, WIDTH, STAGES);

  logic [P*WIDTH-1:0] padded;
  wire  [TREE_BITS-1:0] tree;
  wire  [STAGES:0]      vld;
  logic                 sat_out;

  always_comb begin
    padded = '0;
    padded[N_WORDS*WIDTH-1:0] = bus.WORDS;
  end

  assign tree[0 +: P*WIDTH] = padded;
  assign vld[0]             = bus.IN_VALID;

  for (genvar l = 1; l <= STAGES; l++) begin : g_level
    adder_level #(
      .IN_COUNT(P >> (l - 1)),
      .IN_WIDTH(WIDTH + l - 1)
    ) u_level (
      .CLK    (CLK),
      .RST    (RST),
      .valid_i(vld[l-1]),
      .data_i (tree[level_offset(P, WIDTH, l - 1) +: (P >> (l - 1)) * (WIDTH + l - 1)]),
      .valid_o(vld[l]),
      .data_o (tree[level_offset(P, WIDTH, l) +: (P >> l) * (WIDTH + l)])
    );
  end

  // SAT_EN rides alongside its sample, advancing only when that level loads.
  if (STAGES > 0) begin : g_sat
    logic [STAGES-1:0] sat_q;
    always_ff @(posedge CLK) begin
      if (vld[0]) sat_q[0] <= bus.SAT_EN;
      for (int l = 1; l < STAGES; l++) begin
        if (vld[l]) sat_q[l] <= sat_q[l-1];
      end
    end
    assign sat_out = sat_q[STAGES-1];
  end else begin : g_no_sat
    assign sat_out = bus.SAT_EN;
  end

  logic signed [OUT_WIDTH-1:0] final_sum;
  logic signed [OUT_WIDTH-1:0] res_d;
  logic                        ovf_d;
  logic signed [OUT_WIDTH-1:0] res_q;
  logic                        ovf_q;
  logic                        out_valid_q;
  sat_t                        sat_r;

  always_comb begin
    final_sum = $signed(tree[LAST_OFF +: OUT_WIDTH]);
    sat_r     = saturate(64'(final_sum), WIDTH);
    res_d     = sat_out ? OUT_WIDTH'(sat_r.value) : final_sum;
    ovf_d     = sat_r.ovf;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= vld[STAGES];
      if (vld[STAGES]) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign bus.OUT_VALID = out_valid_q;
  assign bus.RES       = res_q;
  assign bus.OVF       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree: a 4-word build and a 5-word
// (non-power-of-two) build driven side by side.
module tb_pipelined_adder_tree;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipelined_adder_tree_if #(.N_WORDS(4), .WIDTH(25)) bus4 ();
  pipelined_adder_tree_if #(.N_WORDS(5), .WIDTH(25)) bus5 ();

  pipelined_adder_tree #(.N_WORDS(4), .WIDTH(25)) u_dut4 (
    .CLK(clk), .RST(rst), .bus(bus4)
  );
  pipelined_adder_tree #(.N_WORDS(5), .WIDTH(25)) u_dut5 (
    .CLK(clk), .RST(rst), .bus(bus5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect4(input string tag, input bit v, input longint res, input bit ovf);
    check({tag, ".valid"}, 64'(bus4.OUT_VALID), 64'(v));
    check({tag, ".res"},   64'($signed(bus4.RES)), res);
    check({tag, ".ovf"},   64'(bus4.OVF), 64'(ovf));
  endtask

  task automatic expect5(input string tag, input bit v, input longint res, input bit ovf);
    check({tag, ".valid"}, 64'(bus5.OUT_VALID), 64'(v));
    check({tag, ".res"},   64'($signed(bus5.RES)), res);
    check({tag, ".ovf"},   64'(bus5.OVF), 64'(ovf));
  endtask

  task automatic drive4(input bit v, input bit s, input int w0, input int w1,
                        input int w2, input int w3);
    bus4.IN_VALID = v;
    bus4.SAT_EN   = s;
    bus4.WORDS    = {25'(w3), 25'(w2), 25'(w1), 25'(w0)};
  endtask

  task automatic drive5(input bit v, input bit s, input int w0, input int w1,
                        input int w2, input int w3, input int w4);
    bus5.IN_VALID = v;
    bus5.SAT_EN   = s;
    bus5.WORDS    = {25'(w4), 25'(w3), 25'(w2), 25'(w1), 25'(w0)};
  endtask

  initial begin
    drive4(0, 0, 0, 0, 0, 0);
    drive5(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    expect4("reset4", 0, 0, 0);
    expect5("reset5", 0, 0, 0);
    rst = 1'b0;

    // Basic sum, latency 3, single-cycle valid, RES holds afterwards.
    drive4(1, 0, 4, 4, 4, 5);
    tick();
    drive4(0, 0, 0, 0, 0, 0);
    expect4("basic.t1", 0, 0, 0);
    tick();
    expect4("basic.t2", 0, 0, 0);
    tick();
    expect4("basic.out", 1, 17, 0);
    tick();
    expect4("basic.hold", 0, 17, 0);

    // Back-to-back samples 1, -2, 100, 0.
    drive4(1, 0, 1, 0, 0, 0);
    tick();
    expect4("b2b.t1", 0, 17, 0);
    drive4(1, 0, -1, -1, 0, 0);
    tick();
    expect4("b2b.t2", 0, 17, 0);
    drive4(1, 0, 25, 25, 25, 25);
    tick();
    expect4("b2b.s0", 1, 1, 0);
    drive4(1, 0, 5, -5, 7, -7);
    tick();
    expect4("b2b.s1", 1, -2, 0);
    drive4(0, 0, 0, 0, 0, 0);
    tick();
    expect4("b2b.s2", 1, 100, 0);
    tick();
    expect4("b2b.s3", 1, 0, 0);
    tick();
    expect4("b2b.idle", 0, 0, 0);

    // Positive overflow, SAT_EN switched mid-stream.
    drive4(1, 0, 16777215, 16777215, 16777215, 16777215);
    tick();
    drive4(1, 1, 16777215, 16777215, 16777215, 16777215);
    tick();
    drive4(0, 0, 0, 0, 0, 0);
    tick();
    expect4("posovf.nosat", 1, 67108860, 1);
    tick();
    expect4("posovf.sat", 1, 16777215, 1);
    tick();
    expect4("posovf.hold", 0, 16777215, 1);

    // Negative saturation then exact cancellation.
    drive4(1, 1, -16777216, -16777216, -16777216, -16777216);
    tick();
    drive4(1, 1, 16777215, 16777215, -16777216, -16777216);
    tick();
    drive4(0, 0, 0, 0, 0, 0);
    tick();
    expect4("negsat", 1, -16777216, 1);
    tick();
    expect4("cancel", 1, -2, 0);
    tick();
    expect4("cancel.hold", 0, -2, 0);

    // Reset with a sample in flight: it must never emerge.
    drive4(1, 0, 1, 1, 1, 1);
    tick();
    drive4(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect4("midrst.r", 0, 0, 0);
    tick();
    expect4("midrst.t1", 0, 0, 0);
    tick();
    expect4("midrst.t2", 0, 0, 0);
    tick();
    expect4("midrst.t3", 0, 0, 0);
    drive4(1, 0, 2, 3, 4, 5);
    tick();
    drive4(0, 0, 0, 0, 0, 0);
    tick();
    expect4("postrst.t2", 0, 0, 0);
    tick();
    expect4("postrst.out", 1, 14, 0);

    // RST together with IN_VALID: reset wins.
    drive4(1, 0, 7, 7, 7, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive4(0, 0, 0, 0, 0, 0);
    expect4("simrst.r", 0, 0, 0);
    tick();
    expect4("simrst.t1", 0, 0, 0);
    tick();
    expect4("simrst.t2", 0, 0, 0);
    tick();
    expect4("simrst.t3", 0, 0, 0);

    // Five-word build: latency 4, zero-padded tree.
    drive5(1, 0, 1, 2, 3, 4, 5);
    tick();
    drive5(0, 0, 0, 0, 0, 0, 0);
    expect5("n5.t1", 0, 0, 0);
    tick();
    expect5("n5.t2", 0, 0, 0);
    tick();
    expect5("n5.t3", 0, 0, 0);
    tick();
    expect5("n5.out", 1, 15, 0);
    tick();
    expect5("n5.hold", 0, 15, 0);

    drive5(1, 0, 16777215, 16777215, 16777215, 16777215, 16777215);
    tick();
    drive5(1, 1, -16777216, -16777216, -16777216, -16777216, -16777216);
    tick();
    drive5(0, 0, 0, 0, 0, 0, 0);
    tick();
    expect5("n5ovf.t3", 0, 15, 0);
    tick();
    expect5("n5ovf.pos", 1, 83886075, 1);
    tick();
    expect5("n5ovf.negsat", 1, -16777216, 1);
    tick();
    expect5("n5ovf.hold", 0, -16777216, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_adder_tree.md
Name: pipelined_adder_tree

Overview:
Parametrised, fully pipelined signed adder tree. It sums N_WORDS signed words of WIDTH bits into one result and accepts one new sample per clock. It adds a valid pipeline, runtime-selectable saturation and an overflow flag. It is the successor of the fixed 4-input, 25-bit single-stage adder, and it sits in the datapath between the word sources and the downstream accumulator.

Parameters:
N_WORDS, 4, number of signed input words; must be >= 1; not required to be a power of two
WIDTH, 25, bit width of each signed input word
STAGES, clog2(N_WORDS), number of tree levels (derived; not to be overridden)
OUT_WIDTH, WIDTH+STAGES, width of RES; holds the exact full-precision sum

Ports:
CLK  in  1  clock; all logic on the rising edge
RST  in  1  synchronous, active-high reset
IN_VALID  in  1  WORDS and SAT_EN are valid this cycle
WORDS  in  N_WORDS*WIDTH  packed signed inputs; word k is WORDS[k*WIDTH +: WIDTH]
SAT_EN  in  1  1 = clamp the result to the signed WIDTH range; 0 = full-precision result
OUT_VALID  out  1  RES and OVF are valid this cycle
RES  out  OUT_WIDTH  signed sum, sign-extended to OUT_WIDTH when saturated
OVF  out  1  exact sum lies outside the signed WIDTH range

Behaviour:
- Reset (synchronous, active-high):
  - OUT_VALID=0, RES=0, OVF=0.
  - All internal valid bits cleared.
  - Samples in flight when RST is high are discarded and never appear at the output.
- Tree structure:
  - Inputs are zero-padded to P = 2^STAGES words.
  - Level L (L=1..STAGES) adds pairs from level L-1 into registers of WIDTH+L bits; each add is exact and sign-extended.
  - No truncation at any level.
- Output stage:
  - One extra register after the last tree level performs the saturation and overflow checks.
- Latency:
  - OUT_VALID rises exactly STAGES+1 cycles after the IN_VALID cycle.
  - N_WORDS=1 gives latency 1 (STAGES=0, output stage only).
- Throughput:
  - One sample per cycle; no backpressure; no stalls.
  - IN_VALID may be high on consecutive cycles.
- Valid pipeline:
  - A shift register of STAGES+1 bits tracks each sample.
  - Data registers at a level load only when that level's incoming valid bit is 1; otherwise they hold their value.
  - RES and OVF hold their last value while OUT_VALID=0.
- SAT_EN is sampled with IN_VALID and travels with its sample. Changing it mid-stream affects only samples accepted after the change.
- Overflow and saturation, with S = exact sum, MAX = 2^(WIDTH-1)-1, MIN = -2^(WIDTH-1):
  - OVF = (S > MAX) or (S < MIN), regardless of SAT_EN.
  - SAT_EN=1: RES = clamp(S, MIN, MAX), sign-extended to OUT_WIDTH.
  - SAT_EN=0: RES = S.
- Simultaneous RST and IN_VALID: reset wins and the sample is dropped.
- There is no internal state beyond the pipeline; no wrap-around is possible because intermediate widths grow by 1 bit per level.

Decomposition:
- Package adder_pkg holds:
  - clog2 constant function.
  - Signed MAX/MIN helper functions parametrised by width.
  - A saturate function returning the clamped value plus the OVF bit.
- Sub-module adder_level holds one registered tree level:
  - Parameters: IN_COUNT, IN_WIDTH.
  - Ports: CLK, RST, valid in/out, packed inputs, packed IN_COUNT/2 outputs of width IN_WIDTH+1.
  - Generated STAGES times by the top level.
- The top level contains the zero-pad, the generate loop and the output saturation register.

Test Plan:
- Basic sum (N_WORDS=4, WIDTH=25): WORDS={4,4,4,5}, IN_VALID=1 for one cycle, SAT_EN=0 -> 3 cycles later OUT_VALID=1 for exactly one cycle, RES=17, OVF=0; RES holds 17 afterwards.
- Back-to-back throughput: IN_VALID high on 4 consecutive cycles with sums 1, -2, 100, 0 -> OUT_VALID high on 4 consecutive cycles, RES=1, -2, 100, 0 in order.
- Positive overflow: all words = 16777215.
  - SAT_EN=0 -> RES=67108860, OVF=1.
  - Same words with SAT_EN=1 on the next cycle -> RES=16777215, OVF=1.
- Negative saturation and exact cancellation:
  - All words = -16777216 with SAT_EN=1 -> RES=-16777216, OVF=1.
  - {16777215, 16777215, -16777216, -16777216} -> RES=-2, OVF=0.
- Reset mid-operation: accept a sample, assert RST for one cycle on the next edge -> OUT_VALID stays 0, RES=0, OVF=0. A sample accepted after RST falls appears with normal latency.
- Non-power-of-two build (N_WORDS=5): WORDS={1,2,3,4,5} -> latency 4 cycles, RES=15, OUT_WIDTH=28.
